seq_detector_param: RTL and testbench

Parametrised successor to the team's fixed serial-input FSM: a serial pattern detector with a programmable PAT_W-bit pattern. It supports overlapping and non-overlapping modes, a qualifying valid strobe on the serial bit, and a saturating match counter. It sits between a serial bit source and downstream control logic. The 2-bit status output Y keeps the existing FSM's X-in / Y-out style.

---
 rtl/seq_detector_param_pkg.sv | 18 +
 rtl/seq_detector_param_sat.sv | 40 ++++
 rtl/seq_detector_param.sv | 97 +++++++++
 tb/tb_seq_detector_param.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/seq_detector_param_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Holds the FSM state encoding, legal pattern-width bounds and saturating increment.
package seq_detector_param_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } det_state_t;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Values already at or above the ceiling stay at the ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat.sv
// CNT_W-bit saturating counter; clr has priority over inc.
// Count updates one edge after inc/clr; holds at 2^CNT_W-1.
module seq_detector_param_sat
    import seq_detector_param_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [31:0] MAX32 = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), MAX32));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with programmable pattern, overlap mode and match counter.
// Y[0] pulses one edge after the completing valid bit; load wins over x_valid.
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1011)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             X,
    input  logic             x_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic [1:0]       Y,
    output logic [CNT_W-1:0] match_count
);

    localparam int              FCW  = $clog2(PAT_W + 1);
    localparam logic [FCW-1:0]  FULL = FCW'(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detector_param: PAT_W out of range");
    end

    det_state_t       state_q, state_d;
    logic [PAT_W-1:0] window_q, window_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [FCW-1:0]   fill_q, fill_d;
    logic             y0_q, y0_d;

    logic [PAT_W-1:0] window_sh;
    logic [FCW-1:0]   fill_nx;
    logic             match;

    // Match is judged on the post-shift window so the completing bit counts.
    assign window_sh = {window_q[PAT_W-2:0], X};
    assign fill_nx   = (fill_q == FULL) ? fill_q : fill_q + FCW'(1);
    assign match     = x_valid && !load && (window_sh == pat_q) && (fill_nx == FULL);

    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        pat_d    = pat_q;
        fill_d   = fill_q;
        y0_d     = 1'b0;
        if (load) begin
            pat_d    = pattern;
            window_d = '0;
            fill_d   = '0;
            state_d  = FILL;
        end else if (x_valid) begin
            window_d = window_sh;
            fill_d   = fill_nx;
            state_d  = (fill_nx == FULL) ? RUN : FILL;
            if (match) begin
                y0_d = 1'b1;
                if (!overlap) begin
                    window_d = '0;
                    fill_d   = '0;
                    state_d  = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            window_q <= '0;
            pat_q    <= DEF_PAT;
            fill_q   <= '0;
            y0_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            pat_q    <= pat_d;
            fill_q   <= fill_d;
            y0_q     <= y0_d;
        end
    end

    assign Y = {state_q == RUN, y0_q};

    seq_detector_param_sat #(
        .CNT_W (CNT_W)
    ) u_sat (
        .clk   (clk),
        .reset (reset),
        .clr_i (load),
        .inc_i (match),
        .cnt_o (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param with a CNT_W=2 twin for saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       X = 1'b0;
    logic       x_valid = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pattern = 4'b0000;
    logic       overlap = 1'b1;
    logic [1:0] Y, Y2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .CNT_W(8), .DEF_PAT(4'b1011)) dut (
        .clk(clk), .reset(reset), .X(X), .x_valid(x_valid), .load(load),
        .pattern(pattern), .overlap(overlap), .Y(Y), .match_count(match_count)
    );

    seq_detector_param #(.PAT_W(4), .CNT_W(2), .DEF_PAT(4'b1011)) dut_c2 (
        .clk(clk), .reset(reset), .X(X), .x_valid(x_valid), .load(load),
        .pattern(pattern), .overlap(overlap), .Y(Y2), .match_count(match_count2)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] pat;
        logic       ov;
        logic       v;
        logic       x;
        logic [1:0] exp_y;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [3:0] pat,
                         input logic ov, input logic v, input logic x);
        reset   = rst;
        load    = ld;
        pattern = pat;
        overlap = ov;
        x_valid = v;
        X       = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        // rst ld pat ov v x -> Y cnt
        // reset with activity on the inputs, including a load that must lose
        vecs.push_back('{1,0,4'b0000,1,1,1, 2'b00,0});
        vecs.push_back('{1,1,4'b1111,1,1,0, 2'b00,0});
        // non-overlap on DEF_PAT: 1,0,1,1,0,1,1
        vecs.push_back('{0,0,4'b0000,0,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,0,1,0, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,0,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,0,1,1, 2'b01,1});
        vecs.push_back('{0,0,4'b0000,0,1,0, 2'b00,1});
        vecs.push_back('{0,0,4'b0000,0,1,1, 2'b00,1});
        vecs.push_back('{0,0,4'b0000,0,1,1, 2'b00,1});
        // reload 1011, then overlapping run of the same stream
        vecs.push_back('{0,1,4'b1011,1,0,0, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,0, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b11,1});
        vecs.push_back('{0,0,4'b0000,1,1,0, 2'b10,1});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b10,1});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b11,2});
        // load 1111 with a valid 1 that must be dropped, then five 1s
        vecs.push_back('{0,1,4'b1111,1,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b00,0});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b11,1});
        vecs.push_back('{0,0,4'b0000,1,1,1, 2'b11,2});

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].pat, vecs[i].ov, vecs[i].v, vecs[i].x);
            chk($sformatf("vec%0d_Y", i), 32'(Y), 32'(vecs[i].exp_y));
            chk($sformatf("vec%0d_cnt", i), 32'(match_count), 32'(vecs[i].exp_cnt));
        end

        // gaps in x_valid are transparent: 1,0,<3 idle>,1,1
        drive(0, 1, 4'b1011, 1, 0, 0);
        chk("gap_load_cnt", 32'(match_count), 0);
        drive(0, 0, 4'b0000, 1, 1, 1);
        drive(0, 0, 4'b0000, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 4'b0000, 1, 0, 1);
            chk($sformatf("gap_idle%0d_Y", i), 32'(Y), 0);
        end
        drive(0, 0, 4'b0000, 1, 1, 1);
        chk("gap_pre_Y", 32'(Y), 0);
        drive(0, 0, 4'b0000, 1, 1, 1);
        chk("gap_hit_Y", 32'(Y), 32'(2'b11));
        chk("gap_hit_cnt", 32'(match_count), 1);
        drive(0, 0, 4'b0000, 1, 0, 1);
        chk("gap_after_Y", 32'(Y), 32'(2'b10));

        // saturation: CNT_W=2 twin stops at 3 while the 8-bit copy reaches 5
        drive(0, 1, 4'b1111, 1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 4'b0000, 1, 1, 1);
            if (Y2[0]) pulses++;
        end
        chk("sat_pulses", 32'(pulses), 5);
        chk("sat_cnt2", 32'(match_count2), 3);
        chk("sat_cnt8", 32'(match_count), 5);

        // reset mid-RUN with a valid bit present
        drive(1, 0, 4'b0000, 1, 1, 1);
        chk("rst_mid_Y", 32'(Y), 0);
        chk("rst_mid_cnt2", 32'(match_count2), 0);
        chk("rst_mid_cnt8", 32'(match_count), 0);

        // pattern must be back to 1011 after reset, not the loaded 1111
        drive(0, 0, 4'b0000, 1, 1, 1);
        drive(0, 0, 4'b0000, 1, 1, 1);
        drive(0, 0, 4'b0000, 1, 1, 1);
        drive(0, 0, 4'b0000, 1, 1, 1);
        chk("revert_1111_Y", 32'(Y), 32'(2'b10));
        drive(0, 0, 4'b0000, 1, 1, 0);
        drive(0, 0, 4'b0000, 1, 1, 1);
        drive(0, 0, 4'b0000, 1, 1, 1);
        chk("revert_1011_Y", 32'(Y), 32'(2'b11));
        chk("revert_cnt", 32'(match_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
